// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access-size
// and load-type encodings, the registered bus request payload and
// address-alignment helpers.
package lsu_pkg;

    localparam int unsigned XLEN_W = 32;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // store_size encodings from the decoder (SZ_LOAD marks a load)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_LOAD = 2'b11;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Data-memory request payload held for the life of a REQ phase
    typedef struct packed {
        logic              we;
        logic [XLEN_W-1:0] addr;
        logic [3:0]        be;
        logic [XLEN_W-1:0] wdata;
    } lsu_mem_req_t;

    // Access width of a request, in SZ_* terms, for both loads and stores
    function automatic logic [1:0] lsu_acc_size(input logic [1:0] store_size,
                                                input logic [2:0] funct3);
        logic [1:0] sz;
        sz = store_size;
        if (store_size == SZ_LOAD) begin
            case (funct3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    // Byte offset inside the word with low bits forced to the access width
    function automatic logic [1:0] lsu_eff_off(input logic [1:0] size,
                                               input logic [1:0] a);
        logic [1:0] off;
        case (size)
            SZ_BYTE: off = a;
            SZ_HALF: off = {a[1], 1'b0};
            default: off = 2'b00;
        endcase
        return off;
    endfunction

    // True when the address is not naturally aligned for the access width
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [1:0] a);
        return ((size == SZ_HALF) && a[0]) ||
               ((size == SZ_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store byte enables and
// lane-replicated write data, plus load extraction with sign/zero extension.
// Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        store_size_i,
    input  logic [1:0]        st_off_i,
    input  logic [XLEN_W-1:0] wdata_i,
    output logic [3:0]        be_o,
    output logic [XLEN_W-1:0] wdata_o,
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        ld_off_i,
    input  logic [XLEN_W-1:0] rdata_i,
    output logic [XLEN_W-1:0] ldata_o
);

    logic [XLEN_W-1:0] shifted;

    // Store side: enables follow the offset, data is replicated to every lane
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = '0;
        case (store_size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << st_off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << {st_off_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = '0;
            end
        endcase
    end

    // Load side: shift the addressed lane down, then extend to full width
    always_comb begin
        shifted = rdata_i >> {ld_off_i, 3'b000};
        case (funct3_i)
            F3_LB:   ldata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   ldata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  ldata_o = {24'd0, shifted[7:0]};
            F3_LHU:  ldata_o = {16'd0, shifted[15:0]};
            F3_LW:   ldata_o = rdata_i;
            default: ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a decoded memory access into a req/gnt/rvalid
// data-memory transaction, steers byte lanes, extends load data and stalls
// the core until the access completes or times out.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses skip
// the bus, go straight to DONE and raise a one-cycle misalign pulse. Without
// it the low address bits are forced to the access alignment.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            memory_en,
    input  logic [1:0]      store_size,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic            load_valid,
    output logic [XLEN-1:0] load_data,
    output logic            bus_err,
`ifdef MISALIGN_TRAP_EN
    output logic            misalign,
`endif
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e       state_q;
    lsu_mem_req_t     bus_q;
    logic             mem_req_q;
    logic             store_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load_valid_q;
    logic             bus_err_q;
    logic [XLEN-1:0]  load_data_q;

    logic             req_store_c;
    logic [1:0]       req_size_c;
    logic [1:0]       req_off_c;
    logic             trap_c;
    logic             timeout_hit_c;
    logic [3:0]       st_be_c;
    logic [XLEN-1:0]  st_wdata_c;
    logic [XLEN-1:0]  ld_data_c;

    assign req_store_c = (store_size != SZ_LOAD);
    assign req_size_c  = lsu_acc_size(store_size, funct3);
    assign req_off_c   = lsu_eff_off(req_size_c, addr[1:0]);

    // Timeout counts REQ+WAIT cycles; TIMEOUT of zero disables it
    assign cnt_d         = cnt_q + CNT_W'(1);
    assign timeout_hit_c = (TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT));

    lsu_align u_align (
        .store_size_i (store_size),
        .st_off_i     (req_off_c),
        .wdata_i      (wdata),
        .be_o         (st_be_c),
        .wdata_o      (st_wdata_c),
        .funct3_i     (funct3_q),
        .ld_off_i     (off_q),
        .rdata_i      (mem_rdata),
        .ldata_o      (ld_data_c)
    );

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    assign trap_c   = lsu_misaligned(req_size_c, addr[1:0]);
    assign misalign = misalign_q;

    // Pulse accompanies the IDLE->DONE shortcut of a misaligned access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state_q == IDLE) && memory_en && trap_c;
        end
    end
`else
    assign trap_c = 1'b0;
`endif

    // Transaction sequencer: state, bus request, timeout counter and results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bus_q        <= '0;
            mem_req_q    <= 1'b0;
            store_q      <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            cnt_q        <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            load_data_q  <= '0;
        end else begin
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (memory_en) begin
                        store_q  <= req_store_c;
                        funct3_q <= funct3;
                        off_q    <= req_off_c;
                        cnt_q    <= '0;
                        if (trap_c) begin
                            state_q     <= DONE;
                            load_data_q <= '0;
                        end else begin
                            state_q      <= REQ;
                            mem_req_q    <= 1'b1;
                            bus_q.we     <= req_store_c;
                            bus_q.addr   <= {addr[XLEN-1:2], 2'b00};
                            bus_q.be     <= st_be_c;
                            bus_q.wdata  <= st_wdata_c;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_d;
                    if (timeout_hit_c) begin
                        state_q     <= DONE;
                        mem_req_q   <= 1'b0;
                        bus_q       <= '0;
                        bus_err_q   <= 1'b1;
                        load_data_q <= '0;
                    end else if (mem_gnt) begin
                        state_q   <= store_q ? DONE : WAIT;
                        mem_req_q <= 1'b0;
                        bus_q     <= '0;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (timeout_hit_c) begin
                        state_q     <= DONE;
                        bus_err_q   <= 1'b1;
                        load_data_q <= '0;
                    end else if (mem_rvalid) begin
                        state_q      <= DONE;
                        load_valid_q <= 1'b1;
                        load_data_q  <= ld_data_c;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Core is released in DONE; no stall when it is not accessing memory
    assign stall = memory_en & (state_q != DONE);

    assign load_valid = load_valid_q;
    assign load_data  = load_data_q;
    assign bus_err    = bus_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = bus_q.we;
    assign mem_addr   = bus_q.addr;
    assign mem_be     = bus_q.be;
    assign mem_wdata  = bus_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit with a byte-level reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memory_en;
    logic [1:0]  store_size;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        bus_err;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .memory_en  (memory_en),
        .store_size (store_size),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .load_valid (load_valid),
        .load_data  (load_data),
        .bus_err    (bus_err),
`ifdef MISALIGN_TRAP_EN
        .misalign   (misalign),
`endif
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Number of bytes moved by an access
    function automatic int acc_n(input logic [1:0] sz, input logic [2:0] f3);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        if (sz == 2'b10) return 4;
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Lowest byte touched, rounded down to the access width
    function automatic int acc_off(input int n, input logic [31:0] a);
        return (int'(a[1:0]) / n) * n;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
        int n;
        if (sz == 2'b11) return 4'hF;
        n = acc_n(sz, 3'b000);
        return 4'(((1 << n) - 1) << acc_off(n, a));
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        r = '0;
        if (sz == 2'b11) return r;
        n = acc_n(sz, 3'b000);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int     n;
        bit     sgn;
        longint v;
        longint span;
        case (f3)
            3'b000:  begin n = 1; sgn = 1'b1; end
            3'b001:  begin n = 2; sgn = 1'b1; end
            3'b100:  begin n = 1; sgn = 1'b0; end
            3'b101:  begin n = 2; sgn = 1'b0; end
            default: return rd;
        endcase
        span = longint'(1) << (8 * n);
        v = longint'({32'd0, rd}) >> (8 * acc_off(n, a));
        v = v % span;
        if (sgn && (v >= span / 2)) v = v - span;
        return 32'(v);
    endfunction

    // One complete access with a behavioural memory answering after the given delays
    task automatic do_txn(input logic [1:0] sz, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int gdly, input int rdly);
        int n;
        bit is_ld;
        n     = acc_n(sz, f3);
        is_ld = (sz == 2'b11);
        memory_en  = 1'b1;
        store_size = sz;
        funct3     = f3;
        addr       = a;
        wdata      = wd;
        #1 chk("stall_accept", 32'(stall), 32'd1);
        @(posedge clk); #1;
`ifdef MISALIGN_TRAP_EN
        if ((n > 1) && ((int'(a[1:0]) % n) != 0)) begin
            chk("trap_pulse", 32'(misalign), 32'd1);
            chk("trap_req", 32'(mem_req), 32'd0);
            chk("trap_stall", 32'(stall), 32'd0);
            chk("trap_data", load_data, 32'd0);
            chk("trap_valid", 32'(load_valid), 32'd0);
            memory_en = 1'b0;
            @(posedge clk); #1;
            chk("trap_end", 32'(misalign), 32'd0);
            chk("trap_noreq", 32'(mem_req), 32'd0);
            return;
        end
`endif
        chk("req", 32'(mem_req), 32'd1);
        chk("we", 32'(mem_we), 32'(!is_ld));
        chk("addr", mem_addr, a & 32'hFFFF_FFFC);
        chk("be", 32'(mem_be), 32'(exp_be(sz, a)));
        if (!is_ld) chk("wdata", mem_wdata, exp_wd(sz, wd));
        for (int i = 0; i < gdly; i++) begin
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            @(posedge clk); #1;
            chk("req_hold", 32'(mem_req), 32'd1);
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("req_drop", 32'(mem_req), 32'd0);
        if (is_ld) begin
            #1 chk("stall_wait", 32'(stall), 32'd1);
            for (int i = 0; i < rdly; i++) begin
                mem_gnt = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                chk("wait_novalid", 32'(load_valid), 32'd0);
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            chk("ld_valid", 32'(load_valid), 32'd1);
            chk("ld_data", load_data, exp_ld(f3, a, rd));
        end else begin
            chk("st_novalid", 32'(load_valid), 32'd0);
        end
        #1 chk("stall_done", 32'(stall), 32'd0);
        chk("done_noerr", 32'(bus_err), 32'd0);
        memory_en = 1'b0;
        @(posedge clk); #1;
        chk("valid_pulse", 32'(load_valid), 32'd0);
        chk("idle_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        int n;
        logic [1:0] sz;

        rst_n      = 1'b0;
        memory_en  = 1'b0;
        store_size = 2'b00;
        funct3     = 3'b000;
        addr       = '0;
        wdata      = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_valid", 32'(load_valid), 32'd0);
        chk("rst_data", load_data, 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_txn(2'b10, 3'b000, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 2, 0);
        do_txn(2'b00, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'd0, 0, 0);
        do_txn(2'b01, 3'b000, 32'h0000_0206, 32'h1234_5678, 32'd0, 1, 0);
        do_txn(2'b11, 3'b000, 32'h0000_0102, 32'd0, 32'h0080_FF00, 0, 0);
        do_txn(2'b11, 3'b100, 32'h0000_0102, 32'd0, 32'h0080_FF00, 1, 2);
        do_txn(2'b11, 3'b001, 32'h0000_0202, 32'd0, 32'h8001_7F00, 0, 1);
        do_txn(2'b11, 3'b101, 32'h0000_0202, 32'd0, 32'h8001_7F00, 0, 0);
        do_txn(2'b11, 3'b010, 32'h0000_0101, 32'd0, 32'hCAFE_F00D, 0, 0);

        // Randomised accesses, including odd addresses and unlisted funct3
        for (int t = 0; t < 60; t++) begin
            sz = 2'($urandom_range(0, 3));
            do_txn(sz, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Grant never arrives: bus error after the timeout window
        memory_en  = 1'b1;
        store_size = 2'b11;
        funct3     = 3'b001;
        addr       = 32'h0000_0202;
        @(posedge clk); #1;
        chk("to_req", 32'(mem_req), 32'd1);
        n = 0;
        while (!bus_err && (n < 400)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("to_cycles", 32'(n), 32'd255);
        chk("to_req_drop", 32'(mem_req), 32'd0);
        chk("to_stall", 32'(stall), 32'd0);
        chk("to_novalid", 32'(load_valid), 32'd0);
        chk("to_data", load_data, 32'd0);
        memory_en = 1'b0;
        @(posedge clk); #1;
        chk("to_pulse", 32'(bus_err), 32'd0);

        // Reset while waiting for read data, then a late rvalid
        memory_en  = 1'b1;
        store_size = 2'b11;
        funct3     = 3'b010;
        addr       = 32'h0000_0300;
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt   = 1'b0;
        rst_n     = 1'b0;
        memory_en = 1'b0;
        #1;
        chk("rstw_req", 32'(mem_req), 32'd0);
        chk("rstw_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("late_valid", 32'(load_valid), 32'd0);
        chk("late_data", load_data, 32'd0);
        chk("late_req", 32'(mem_req), 32'd0);
        do_txn(2'b11, 3'b000, 32'h0000_0401, 32'd0, 32'h0000_8000, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
